issue_queue_mw: RTL

//  Parametrised multi-wide in-order issue buffer between decode and issue.
//  - Accepts up to WR_W decoded PC_set entries per cycle.
//  - Presents the oldest RD_W entries combinationally to issue logic, which retires 0..RD_W per cycle.
//  - Successor to the fixed 16-deep dual-issue buffer, adding:

---
 rtl/issue_queue_mw_pkg.sv | 15 +
 rtl/issue_queue_mw_lead_ones.sv | 20 ++
 rtl/issue_queue_mw.sv | 129 ++++++++++++
 3 files changed

// File: rtl/issue_queue_mw_pkg.sv
// Shared types for the issue queue: PC_set entry, default sizing, pointer type.
package issue_queue_mw_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } PC_set;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_WR_W  = 2;
  localparam int IQ_RD_W  = 2;

  typedef logic [$clog2(IQ_DEPTH)-1:0] iq_ptr_t;

endpackage

// File: rtl/issue_queue_mw_lead_ones.sv
// iq_lead_ones: number of consecutive 1s starting at bit 0 of vec_i.
module iq_lead_ones #(
  parameter int W = 2
) (
  input  logic [W-1:0]               vec_i,
  output logic [$clog2(W+1)-1:0]     cnt_o
);
  localparam int CW = $clog2(W+1);

  // walk from lane 0 and stop counting at the first clear bit
  always_comb begin
    logic run;
    run   = 1'b1;
    cnt_o = '0;
    for (int k = 0; k < W; k++) begin
      if (run && vec_i[k]) cnt_o = CW'(k + 1);
      else                 run   = 1'b0;
    end
  end
endmodule

// File: rtl/issue_queue_mw.sv
// issue_queue_mw: multi-wide in-order issue buffer (circular, separate count).
// Optional build macro IQ_PERF_CNT_EN adds saturating full/empty cycle counters.
module issue_queue_mw
  import issue_queue_mw_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int WR_W        = IQ_WR_W,
  parameter int RD_W        = IQ_RD_W,
  parameter int AFULL_SLACK = 6
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         stall,
  input  PC_set [WR_W-1:0]             i_set,
  input  logic [WR_W-1:0]              i_valid,
  input  logic [$clog2(RD_W+1)-1:0]    i_consume,
  output PC_set [RD_W-1:0]             o_set,
  output logic [RD_W-1:0]              o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_afull,
  output logic                         o_overflow
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]                  o_perf_full_cyc,
  output logic [31:0]                  o_perf_empty_cyc
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AW    = CW + 1;
  localparam int PW    = $clog2(WR_W+1);
  localparam int RW    = $clog2(RD_W+1);

  PC_set            mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             afull_q, afull_d, ovf_q, ovf_d;
  logic [PW-1:0]    push_raw, push;
  logic [RW-1:0]    avail, pop;
  logic [AW-1:0]    space, count_nx;
  logic             drop;

  iq_lead_ones #(.W(WR_W)) u_push  (.vec_i(i_valid), .cnt_o(push_raw));
  iq_lead_ones #(.W(RD_W)) u_avail (.vec_i(o_valid), .cnt_o(avail));

  // read side: oldest entries straight from storage, no write bypass
  always_comb begin
    for (int k = 0; k < RD_W; k++) begin
      o_valid[k] = (count_q > CW'(k));
      o_set[k]   = mem_q[tail_q + PTR_W'(k)];
    end
  end

  // pop clamp, space check (pop frees room this cycle), next-state pointers
  always_comb begin
    pop      = stall ? '0 : ((i_consume > avail) ? avail : i_consume);
    space    = AW'(DEPTH) - AW'(count_q) + AW'(pop);
    drop     = (AW'(push_raw) > space);
    push     = drop ? '0 : push_raw;
    count_nx = AW'(count_q) + AW'(push) - AW'(pop);
    head_d   = head_q + PTR_W'(push);
    tail_d   = tail_q + PTR_W'(pop);
    count_d  = count_nx[CW-1:0];
    afull_d  = (count_nx >= AW'(DEPTH - AFULL_SLACK));
    ovf_d    = ovf_q | drop;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      afull_d = 1'b0;
      ovf_d   = ovf_q;
    end
  end

  // control state; overflow is sticky until reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // storage write: accepted lanes land at head+k, wrapping naturally
  always_ff @(posedge clk) begin
    if (rstn && !flush) begin
      for (int k = 0; k < WR_W; k++)
        if (PW'(k) < push) mem_q[head_q + PTR_W'(k)] <= i_set[k];
    end
  end

  // issue logic must never consume more than it was shown
  always_ff @(posedge clk) begin
    if (rstn && !stall && !flush)
      assert (i_consume <= avail) else $error("issue_queue_mw: i_consume exceeds o_valid");
  end

  assign o_count    = count_q;
  assign o_afull    = afull_q;
  assign o_overflow = ovf_q;

`ifdef IQ_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_empty_q;

  // saturating occupancy-extreme counters; flush does not clear them
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (count_q == CW'(DEPTH) && perf_full_q != '1) perf_full_q  <= perf_full_q + 32'd1;
      if (count_q == '0 && perf_empty_q != '1)        perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign o_perf_full_cyc  = perf_full_q;
  assign o_perf_empty_cyc = perf_empty_q;
`endif

endmodule
